// File: rtl/sprite_blitter.sv
// Walks a rectangular sprite row by row, fetching each pixel from a synchronous ROM and emitting visible ones.
// Latency: start -> first pixel in 2 cycles; 2 cycles per pixel (written or skipped); done 1 cycle after the last pixel.
// Backpressure: an emitted pixel holds x/y/data until program_ready; transparent or clipped pixels never stall.
module sprite_blitter #(
    parameter int          ROM_ADDR_W  = 16,
    parameter logic [15:0] TRANSPARENT = 16'hF81F,
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [9:0]            sprite_x,
    input  logic [9:0]            sprite_y,
    input  logic [6:0]            sprite_w,
    input  logic [6:0]            sprite_h,
    input  logic [ROM_ADDR_W-1:0] sprite_base,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [15:0]           rom_data,
    output logic [9:0]            program_x,
    output logic [9:0]            program_y,
    output logic [15:0]           program_data,
    output logic                  program_write,
    input  logic                  program_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_DONE} state_t;

    localparam logic [10:0] SCR_W = 11'(SCREEN_W);
    localparam logic [10:0] SCR_H = 11'(SCREEN_H);

    state_t                state_q, state_d;
    logic [9:0]            x_q, x_d, y_q, y_d;
    logic [6:0]            w_q, w_d, h_q, h_d;
    logic [6:0]            col_q, col_d, row_q, row_d;
    logic [ROM_ADDR_W-1:0] rom_ptr_q, rom_ptr_d;
    logic [15:0]           pix_q, pix_d;
    logic                  hold_q, hold_d;

    logic [10:0] px, py;
    logic [15:0] pix_cur;
    logic        in_emit, clipped, skip, col_last, is_last;

    // Pixel datapath: screen coordinate, colour source and skip decision for the current EMIT cycle
    always_comb begin
        px       = {1'b0, x_q} + {4'b0000, col_q};
        py       = {1'b0, y_q} + {4'b0000, row_q};
        // First EMIT cycle reads the ROM directly; stalled cycles use the captured copy
        pix_cur  = hold_q ? pix_q : rom_data;
        in_emit  = (state_q == S_EMIT);
        clipped  = (px >= SCR_W) || (py >= SCR_H);
        skip     = clipped || (pix_cur == TRANSPARENT);
        col_last = (col_q == w_q - 7'd1);
        is_last  = col_last && (row_q == h_q - 7'd1);
    end

    // Next-state logic: request latch, fetch/emit sequencing and pixel advance
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        w_d       = w_q;
        h_d       = h_q;
        col_d     = col_q;
        row_d     = row_q;
        rom_ptr_d = rom_ptr_q;
        pix_d     = pix_q;
        hold_d    = hold_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d       = sprite_x;
                    y_d       = sprite_y;
                    w_d       = sprite_w;
                    h_d       = sprite_h;
                    col_d     = 7'd0;
                    row_d     = 7'd0;
                    rom_ptr_d = sprite_base;
                    hold_d    = 1'b0;
                    state_d   = (sprite_w == 7'd0 || sprite_h == 7'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                hold_d  = 1'b0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                pix_d = pix_cur;
                if (skip || program_ready) begin
                    hold_d    = 1'b0;
                    rom_ptr_d = rom_ptr_q + ROM_ADDR_W'(1);
                    if (col_last) begin
                        col_d = 7'd0;
                        row_d = row_q + 7'd1;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                    state_d = is_last ? S_DONE : S_FETCH;
                end else begin
                    hold_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any request in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            rom_ptr_q <= '0;
            pix_q     <= '0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            w_q       <= w_d;
            h_q       <= h_d;
            col_q     <= col_d;
            row_q     <= row_d;
            rom_ptr_q <= rom_ptr_d;
            pix_q     <= pix_d;
            hold_q    <= hold_d;
        end
    end

    assign rom_addr      = rom_ptr_q;
    assign program_write = in_emit && !skip;
    assign program_x     = in_emit ? px[9:0] : 10'd0;
    assign program_y     = in_emit ? py[9:0] : 10'd0;
    assign program_data  = in_emit ? pix_cur : 16'd0;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);

endmodule
